cic_comp_fir: RTL and testbench

//  Post-CIC compensation FIR. Sits directly downstream of the CIC decimator.

---
 rtl/cic_comp_fir_if.sv | 29 ++
 rtl/cic_comp_fir.sv | 137 +++++++++++++
 tb/tb_cic_comp_fir.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cic_comp_fir_if.sv
// cic_comp_fir_if: PCM sample/result and coefficient-load signals of the
// post-CIC compensation FIR, grouped for the filter (slave) and its driver (master).
interface cic_comp_fir_if #(
    parameter int W    = 16,
    parameter int TAPS = 16,
    parameter int CW   = 16
) ();
    localparam int AW = $clog2(TAPS);

    logic                 en_pcm;
    logic signed [W-1:0]  din;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic signed [W-1:0]  dout;
    logic                 dout_valid;
    logic                 busy;
    logic                 overrun;

    modport master (
        output en_pcm, din, coef_we, coef_addr, coef_data,
        input  dout, dout_valid, busy, overrun
    );

    modport slave (
        input  en_pcm, din, coef_we, coef_addr, coef_data,
        output dout, dout_valid, busy, overrun
    );
endinterface

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: post-CIC compensation FIR. One sample per en_pcm strobe is
// shifted into a TAPS-deep history, then a single MAC runs TAPS cycles over
// the loadable Q2.(CW-2) coefficients and one result is emitted.
// Define CIC_FIR_SAT_EN to clamp the result to W bits; otherwise it wraps.
module cic_comp_fir #(
    parameter int W    = 16,
    parameter int TAPS = 16,
    parameter int CW   = 16
) (
    input  logic          clk,
    input  logic          reset,
    cic_comp_fir_if.slave bus
);
    localparam int AW   = $clog2(TAPS);
    localparam int ACCW = W + CW + AW;
    localparam int SH   = CW - 2;
    localparam logic signed [CW-1:0] COEF_ONE = {2'b01, {(CW-2){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t                 state_q, state_d;
    logic signed [W-1:0]    hist_q [TAPS];
    logic signed [W-1:0]    hist_d [TAPS];
    logic signed [CW-1:0]   coef_q [TAPS];
    logic signed [CW-1:0]   coef_d [TAPS];
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic signed [W-1:0]    dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   overrun_q, overrun_d;
    logic signed [W+CW-1:0] prod;
    logic signed [W-1:0]    result;

    // Full-precision product of the current tap
    always_comb begin
        prod = (W+CW)'(hist_q[idx_q]) * (W+CW)'(coef_q[idx_q]);
    end

`ifdef CIC_FIR_SAT_EN
    logic signed [ACCW-SH-1:0] shifted;

    // Scale by the coefficient unity and clamp to the W-bit range
    always_comb begin
        shifted = (ACCW-SH)'(acc_q >>> SH);
        if (!shifted[ACCW-SH-1] && (|shifted[ACCW-SH-2:W-1])) begin
            result = {1'b0, {(W-1){1'b1}}};
        end else if (shifted[ACCW-SH-1] && !(&shifted[ACCW-SH-2:W-1])) begin
            result = {1'b1, {(W-1){1'b0}}};
        end else begin
            result = shifted[W-1:0];
        end
    end
`else
    // Scale by the coefficient unity and keep the low W bits (wraps)
    always_comb begin
        result = W'(acc_q >>> SH);
    end
`endif

    // FSM next state, history shift, coefficient load and MAC datapath
    always_comb begin
        state_d      = state_q;
        hist_d       = hist_q;
        coef_d       = coef_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overrun_d    = overrun_q | (bus.en_pcm && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (bus.en_pcm) begin
                    for (int unsigned k = 1; k < TAPS; k++) begin
                        hist_d[k] = hist_q[k-1];
                    end
                    hist_d[0] = bus.din;
                    acc_d     = '0;
                    idx_d     = '0;
                    state_d   = MAC;
                end else if (bus.coef_we &&
                             (int'(bus.coef_addr) < TAPS)) begin
                    coef_d[bus.coef_addr] = bus.coef_data;
                end
            end
            MAC: begin
                acc_d = acc_q + ACCW'(prod);
                idx_d = idx_q + AW'(1);
                if (idx_q == AW'(TAPS - 1)) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                dout_d       = result;
                dout_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset restores the identity filter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            for (int unsigned k = 0; k < TAPS; k++) begin
                hist_q[k] <= '0;
                coef_q[k] <= (k == 0) ? COEF_ONE : '0;
            end
            acc_q        <= '0;
            idx_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            coef_q       <= coef_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: directed bench for cic_comp_fir with a reference model
// and an expected-result queue checked whenever dout_valid pulses.
module tb_cic_comp_fir;
    localparam int W    = 16;
    localparam int TAPS = 16;
    localparam int CW   = 16;
    localparam int LAT  = TAPS + 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cic_comp_fir_if #(.W(W), .TAPS(TAPS), .CW(CW)) bus ();

    cic_comp_fir #(.W(W), .TAPS(TAPS), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic signed [W-1:0] val;
        int                  due;
    } exp_t;

    exp_t                 sbq[$];
    logic signed [W-1:0]  mhist [TAPS];
    logic signed [CW-1:0] mcoef [TAPS];

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) begin
            mhist[i] = '0;
            mcoef[i] = (i == 0) ? 16'sd16384 : 16'sd0;
        end
    endfunction

    function automatic void model_shift(input logic signed [W-1:0] d);
        for (int i = TAPS - 1; i > 0; i--) mhist[i] = mhist[i-1];
        mhist[0] = d;
    endfunction

    function automatic logic signed [W-1:0] model_out();
        longint acc = 0;
        for (int i = 0; i < TAPS; i++)
            acc += longint'(mhist[i]) * longint'(mcoef[i]);
        acc = acc >>> (CW - 2);
`ifdef CIC_FIR_SAT_EN
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
`endif
        return W'(acc);
    endfunction

    // Scoreboard: every dout_valid must match the oldest expectation on time
    always @(negedge clk) begin
        if (bus.dout_valid) begin
            chk("valid_expected", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("dout", bus.dout, e.val);
                chk("latency", cyc, e.due);
            end
        end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
            chk("valid_missing", bus.dout_valid, 1);
            void'(sbq.pop_front());
        end
    end

    task automatic do_reset();
        @(negedge clk);
        bus.en_pcm = 1'b0;
        bus.coef_we = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_dout", bus.dout, 0);
        chk("rst_valid", bus.dout_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overrun", bus.overrun, 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic strobe(input logic signed [W-1:0] d, input bit accept);
        @(negedge clk);
        bus.din    = d;
        bus.en_pcm = 1'b1;
        @(posedge clk);
        #1;
        bus.en_pcm = 1'b0;
        chk("busy_after_strobe", bus.busy, 1);
        if (accept) begin
            model_shift(d);
            sbq.push_back('{val: model_out(), due: cyc + LAT});
        end else begin
            chk("overrun_set", bus.overrun, 1);
        end
    endtask

    task automatic wcoef(input logic [3:0] a, input logic signed [CW-1:0] d,
                         input bit apply);
        @(negedge clk);
        bus.coef_we   = 1'b1;
        bus.coef_addr = a;
        bus.coef_data = d;
        @(posedge clk);
        #1;
        bus.coef_we = 1'b0;
        if (apply) mcoef[a] = d;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3 * LAT && sbq.size() != 0; i++) @(negedge clk);
        chk("drain", sbq.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en_pcm    = 1'b0;
        bus.din       = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        model_reset();

        // 1: identity filter after reset
        do_reset();
        strobe(16'sd1000, 1'b1);
        repeat (5) @(negedge clk);
        chk("dout_before_first", bus.dout, 0);
        wait_drain();
        strobe(-16'sd5, 1'b1);
        wait_drain();

        // 2: four-tap response to an impulse of 1000
        do_reset();
        wcoef(4'd0, 16'sd16384, 1'b1);
        wcoef(4'd1, 16'sd8192, 1'b1);
        wcoef(4'd2, -16'sd16384, 1'b1);
        wcoef(4'd3, 16'sd4096, 1'b1);
        strobe(16'sd1000, 1'b1);
        repeat (19) @(negedge clk);
        strobe(16'sd0, 1'b1);
        repeat (19) @(negedge clk);
        strobe(16'sd0, 1'b1);
        repeat (19) @(negedge clk);
        strobe(16'sd0, 1'b1);
        wait_drain();

        // 3: strobe while busy is dropped and flags overrun
        do_reset();
        strobe(16'sd7, 1'b1);
        repeat (4) @(negedge clk);
        strobe(16'sd99, 1'b0);
        wait_drain();
        wcoef(4'd0, 16'sd0, 1'b1);
        wcoef(4'd1, 16'sd16384, 1'b1);
        strobe(16'sd0, 1'b1);
        wait_drain();
        chk("overrun_sticky", bus.overrun, 1);

        // 4: large gain, saturate or wrap
        do_reset();
        wcoef(4'd0, 16'sd32767, 1'b1);
        strobe(16'sd30000, 1'b1);
        wait_drain();
`ifdef CIC_FIR_SAT_EN
        chk("big_dout", bus.dout, 32767);
`else
        chk("big_dout", bus.dout, -5538);
`endif

        // 5: reset in the middle of the MAC aborts the result
        do_reset();
        wcoef(4'd0, 16'sd8192, 1'b1);
        @(negedge clk);
        bus.din    = 16'sd500;
        bus.en_pcm = 1'b1;
        @(posedge clk);
        #1;
        bus.en_pcm = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_dout", bus.dout, 0);
        chk("abort_valid", bus.dout_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (25) @(negedge clk);
        strobe(16'sd42, 1'b1);
        wait_drain();

        // 6: coefficient writes while busy or with an accepted strobe are ignored
        strobe(16'sd10, 1'b1);
        repeat (3) @(negedge clk);
        wcoef(4'd0, 16'sd0, 1'b0);
        wait_drain();
        strobe(16'sd123, 1'b1);
        wait_drain();
        @(negedge clk);
        bus.din       = 16'sd77;
        bus.en_pcm    = 1'b1;
        bus.coef_we   = 1'b1;
        bus.coef_addr = 4'd0;
        bus.coef_data = 16'sd0;
        @(posedge clk);
        #1;
        bus.en_pcm  = 1'b0;
        bus.coef_we = 1'b0;
        model_shift(16'sd77);
        sbq.push_back('{val: model_out(), due: cyc + LAT});
        wait_drain();
        strobe(-16'sd321, 1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
